line_slide_merge: RTL

//  Parametrised sequential slide-and-merge engine for one 2048 line (row or column) of N tiles.

---
 rtl/game2048_pkg.sv | 22 ++
 rtl/tile_merge_step.sv | 46 ++++
 rtl/line_slide_merge.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/game2048_pkg.sv
// rtl/game2048_pkg.sv - shared tile, state and direction definitions for the line merge engine
package game2048_pkg;

    localparam int TILE_EMPTY = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        DIR_FWD = 1'b0,
        DIR_REV = 1'b1
    } dir_t;

    function automatic logic [31:0] tile_score(input int unsigned e);
        return 32'd1 << (e + 1);
    endfunction

endpackage

// File: rtl/tile_merge_step.sv
// rtl/tile_merge_step.sv - one slide/merge decision for the incoming tile against the held tile
module tile_merge_step
    import game2048_pkg::*;
#(
    parameter int VW      = 4,
    parameter int SCORE_W = 20
) (
    input  logic [VW-1:0]      hold,
    input  logic               hold_v,
    input  logic [VW-1:0]      tile,
    output logic               wr_en,
    output logic [VW-1:0]      wr_val,
    output logic [VW-1:0]      hold_nxt,
    output logic               hold_v_nxt,
    output logic               merged,
    output logic [SCORE_W-1:0] score_add
);

    localparam logic [VW-1:0] MAX_EXP = {VW{1'b1}};

    always_comb begin
        wr_en      = 1'b0;
        wr_val     = hold;
        hold_nxt   = hold;
        hold_v_nxt = hold_v;
        merged     = 1'b0;
        score_add  = '0;
        if (tile != VW'(TILE_EMPTY)) begin
            // saturated tiles never combine, so the exponent cannot overflow
            if (hold_v && hold == tile && tile != MAX_EXP) begin
                wr_en      = 1'b1;
                wr_val     = hold + VW'(1);
                hold_v_nxt = 1'b0;
                merged     = 1'b1;
                score_add  = SCORE_W'(tile_score(32'(tile)));
            end else if (hold_v) begin
                wr_en    = 1'b1;
                hold_nxt = tile;
            end else begin
                hold_nxt   = tile;
                hold_v_nxt = 1'b1;
            end
        end
    end

endmodule

// File: rtl/line_slide_merge.sv
// rtl/line_slide_merge.sv - sequential slide-and-merge of one 2048 line; WIN_DETECT_EN adds win output
module line_slide_merge
    import game2048_pkg::*;
#(
    parameter int N       = 4,
    parameter int VW      = 4,
    parameter int SCORE_W = 20
`ifdef WIN_DETECT_EN
    ,
    parameter int WIN_EXP = 11
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       dir_rev,
    input  logic [N*VW-1:0]            line_in,
    output logic                       busy,
    output logic                       done,
    output logic [N*VW-1:0]            line_out,
    output logic                       moved,
    output logic [$clog2(N/2+1)-1:0]   merge_count,
`ifdef WIN_DETECT_EN
    output logic                       win,
`endif
    output logic [SCORE_W-1:0]         score_inc
);

    localparam int IW  = $clog2(N);
    localparam int MCW = $clog2(N/2+1);

    state_t             state, state_nxt;
    dir_t               dir_q;
    logic [VW-1:0]      tiles [N];
    logic [VW-1:0]      res   [N];
    logic [N*VW-1:0]    orig;
    logic [IW-1:0]      rd, wr;
    logic [VW-1:0]      hold;
    logic               hold_v;
    logic [MCW-1:0]     mc_acc;
    logic [SCORE_W-1:0] score_acc;
    logic [N*VW-1:0]    line_fin;
    logic [VW-1:0]      fin_v;

    logic               wr_en, hold_v_nxt, merged;
    logic [VW-1:0]      wr_val, hold_nxt;
    logic [SCORE_W-1:0] score_add;

    tile_merge_step #(.VW(VW), .SCORE_W(SCORE_W)) u_step (
        .hold       (hold),
        .hold_v     (hold_v),
        .tile       (tiles[rd]),
        .wr_en      (wr_en),
        .wr_val     (wr_val),
        .hold_nxt   (hold_nxt),
        .hold_v_nxt (hold_v_nxt),
        .merged     (merged),
        .score_add  (score_add)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != ST_IDLE);
        done      = (state == ST_DONE);
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_SCAN;
            ST_SCAN:  if (rd == IW'(N-1)) state_nxt = ST_FLUSH;
            ST_FLUSH: state_nxt = ST_DONE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Final line: pending held tile lands at wr, then undo the capture-time reversal
    always_comb begin
        line_fin = '0;
        fin_v    = '0;
        for (int i = 0; i < N; i++) begin
            fin_v = res[i];
            if (hold_v && IW'(i) == wr) fin_v = hold;
            if (dir_q == DIR_REV) line_fin[(N-1-i)*VW +: VW] = fin_v;
            else                  line_fin[i*VW +: VW]       = fin_v;
        end
    end

`ifdef WIN_DETECT_EN
    logic win_acc;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q       <= DIR_FWD;
            orig        <= '0;
            rd          <= '0;
            wr          <= '0;
            hold        <= '0;
            hold_v      <= 1'b0;
            mc_acc      <= '0;
            score_acc   <= '0;
            line_out    <= '0;
            moved       <= 1'b0;
            merge_count <= '0;
            score_inc   <= '0;
            for (int i = 0; i < N; i++) begin
                tiles[i] <= '0;
                res[i]   <= '0;
            end
`ifdef WIN_DETECT_EN
            win_acc     <= 1'b0;
            win         <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    orig      <= line_in;
                    dir_q     <= dir_t'(dir_rev);
                    rd        <= '0;
                    wr        <= '0;
                    hold      <= '0;
                    hold_v    <= 1'b0;
                    mc_acc    <= '0;
                    score_acc <= '0;
                    for (int i = 0; i < N; i++) begin
                        tiles[i] <= dir_rev ? line_in[(N-1-i)*VW +: VW] : line_in[i*VW +: VW];
                        res[i]   <= '0;
                    end
`ifdef WIN_DETECT_EN
                    win_acc   <= 1'b0;
`endif
                end
                ST_SCAN: begin
                    if (wr_en) begin
                        res[wr] <= wr_val;
                        wr      <= wr + IW'(1);
                    end
                    hold   <= hold_nxt;
                    hold_v <= hold_v_nxt;
                    rd     <= rd + IW'(1);
                    if (merged) begin
                        mc_acc    <= mc_acc + MCW'(1);
                        score_acc <= score_acc + score_add;
                    end
`ifdef WIN_DETECT_EN
                    if (merged && wr_val == VW'(WIN_EXP)) win_acc <= 1'b1;
`endif
                end
                ST_FLUSH: begin
                    line_out    <= line_fin;
                    moved       <= (line_fin != orig);
                    merge_count <= mc_acc;
                    score_inc   <= score_acc;
`ifdef WIN_DETECT_EN
                    win         <= win_acc;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
